// File: rtl/microwave_pkg.sv
// Shared types for the microwave timer path: state encoding, BCD MM:SS payload and validity check.
package microwave_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    localparam mmss_t MAX_MMSS = 16'h9959;

    function automatic logic bcd_valid_mmss(input mmss_t t);
        return (t.min_tens <= 4'd9) && (t.min_ones <= 4'd9) &&
               (t.sec_tens <= 4'd5) && (t.sec_ones <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_mmss_arith.sv
// Combinational MM:SS helpers: decrement by one second and add ADD_N seconds, saturating at 99:59.
module bcd_mmss_arith
    import microwave_pkg::*;
#(
    parameter int unsigned ADD_N = 30
) (
    input  mmss_t value,
    output mmss_t dec_c,
    output logic  dec_zero_c,
    output mmss_t add_c
);

    localparam logic [4:0] N_ONES = 5'(ADD_N % 10);
    localparam logic [4:0] N_TENS = 5'(ADD_N / 10);

    logic [4:0] ones_sum;
    logic [4:0] tens_sum;
    logic       ones_carry;
    logic       sec_carry;

    // Borrow chain; 00:00 stays at 00:00 rather than wrapping.
    always_comb begin
        dec_c = value;
        if (value == '0) begin
            dec_c = '0;
        end else if (value.sec_ones != 4'd0) begin
            dec_c.sec_ones = value.sec_ones - 4'd1;
        end else begin
            dec_c.sec_ones = 4'd9;
            if (value.sec_tens != 4'd0) begin
                dec_c.sec_tens = value.sec_tens - 4'd1;
            end else begin
                dec_c.sec_tens = 4'd5;
                if (value.min_ones != 4'd0) begin
                    dec_c.min_ones = value.min_ones - 4'd1;
                end else begin
                    dec_c.min_ones = 4'd9;
                    dec_c.min_tens = value.min_tens - 4'd1;
                end
            end
        end
    end

    assign dec_zero_c = (dec_c == '0);

    // Seconds carry past 59 bumps minutes; a carry out of 99 minutes saturates.
    always_comb begin
        ones_sum       = 5'(value.sec_ones) + N_ONES;
        ones_carry     = (ones_sum > 5'd9);
        tens_sum       = 5'(value.sec_tens) + N_TENS + 5'(ones_carry);
        sec_carry      = (tens_sum > 5'd5);
        add_c          = value;
        add_c.sec_ones = ones_carry ? 4'(ones_sum - 5'd10) : 4'(ones_sum);
        add_c.sec_tens = sec_carry ? 4'(tens_sum - 5'd6) : 4'(tens_sum);
        if (sec_carry) begin
            if ((value.min_tens == 4'd9) && (value.min_ones == 4'd9)) begin
                add_c = MAX_MMSS;
            end else if (value.min_ones == 4'd9) begin
                add_c.min_ones = 4'd0;
                add_c.min_tens = value.min_tens + 4'd1;
            end else begin
                add_c.min_ones = value.min_ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/cook_countdown.sv
// BCD MM:SS cook timer with start/+30s, door pause, stop/clear and done buzzer.
// Define COOK_CHIME_EN to pulse the buzzer three times in DONE instead of holding it steady.
module cook_countdown
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned BUZZ_CYCLES = 100000000,
    parameter int unsigned ADD_SEC     = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_sec_ones,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_min_ones,
    input  logic [3:0] load_min_tens,
    input  logic       start,
    input  logic       stop,
    input  logic       door_open,
    output logic [3:0] first_second_out,
    output logic [3:0] second_second_out,
    output logic [3:0] first_minute_out,
    output logic [3:0] second_minute_out,
    output logic       power_on,
    output logic       buzzer,
    output logic       busy,
    output logic       load_err,
    output logic [1:0] state_out
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BUZZ_W  = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [BUZZ_W-1:0]  BUZZ_MAX  = BUZZ_W'(BUZZ_CYCLES - 1);

`ifdef COOK_CHIME_EN
    localparam int unsigned CHIME_RAW    = BUZZ_CYCLES / 6;
    localparam int unsigned CHIME_CYCLES = (CHIME_RAW > 0) ? CHIME_RAW : 1;
    localparam int unsigned CHIME_W      = (CHIME_CYCLES > 1) ? $clog2(CHIME_CYCLES) : 1;
    localparam logic [CHIME_W-1:0] CHIME_MAX = CHIME_W'(CHIME_CYCLES - 1);
    logic [CHIME_W-1:0] chime_cnt;
`endif

    state_e              state;
    mmss_t               time_q;
    mmss_t               load_val;
    mmss_t               dec_c;
    mmss_t               add_c;
    logic                dec_zero_c;
    logic [PRESC_W-1:0]  presc;
    logic [BUZZ_W-1:0]   buzz_cnt;
    logic                tick_pend;
    logic                start_d, start_dd, stop_d, stop_dd;
    logic                start_edge_c, stop_edge_c, tick_due_c;

    function automatic logic [1:0] run_flags(input state_e s);
        return {s == COOK, (s == COOK) || (s == PAUSE)};
    endfunction

    assign load_val     = {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones};
    assign start_edge_c = start_d & ~start_dd;
    assign stop_edge_c  = stop_d & ~stop_dd;
    assign tick_due_c   = (state == COOK) && ((presc == PRESC_MAX) || tick_pend);

    bcd_mmss_arith #(.ADD_N(ADD_SEC)) u_arith (
        .value      (time_q),
        .dec_c      (dec_c),
        .dec_zero_c (dec_zero_c),
        .add_c      (add_c)
    );

    // Priority per cycle: stop edge > door open > start edge > tick > DONE timeout > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            time_q    <= '0;
            presc     <= '0;
            buzz_cnt  <= '0;
            tick_pend <= 1'b0;
            start_d   <= 1'b0;
            start_dd  <= 1'b0;
            stop_d    <= 1'b0;
            stop_dd   <= 1'b0;
            power_on  <= 1'b0;
            busy      <= 1'b0;
            buzzer    <= 1'b0;
            load_err  <= 1'b0;
`ifdef COOK_CHIME_EN
            chime_cnt <= '0;
`endif
        end else begin
            start_d  <= start;
            start_dd <= start_d;
            stop_d   <= stop;
            stop_dd  <= stop_d;
            load_err <= 1'b0;
            if (state == COOK) begin
                presc <= (presc == PRESC_MAX) ? '0 : presc + PRESC_W'(1);
            end
            if (stop_edge_c) begin
                tick_pend <= 1'b0;
                buzzer    <= 1'b0;
                if (state == COOK) begin
                    state              <= PAUSE;
                    {power_on, busy}   <= run_flags(PAUSE);
                end else begin
                    state              <= IDLE;
                    time_q             <= '0;
                    {power_on, busy}   <= run_flags(IDLE);
                end
            end else if (door_open && (state == COOK)) begin
                state            <= PAUSE;
                tick_pend        <= 1'b0;
                {power_on, busy} <= run_flags(PAUSE);
            end else if (start_edge_c && !door_open && (state != DONE)) begin
                case (state)
                    IDLE: begin
                        state            <= COOK;
                        presc            <= '0;
                        {power_on, busy} <= run_flags(COOK);
                        if (time_q == '0) time_q <= add_c;
                    end
                    COOK: begin
                        // A tick landing on the add is deferred one cycle.
                        time_q    <= add_c;
                        tick_pend <= tick_due_c;
                    end
                    PAUSE: begin
                        state            <= COOK;
                        {power_on, busy} <= run_flags(COOK);
                    end
                    default: ;
                endcase
            end else if (tick_due_c) begin
                tick_pend <= 1'b0;
                time_q    <= dec_c;
                if (dec_zero_c) begin
                    state            <= DONE;
                    {power_on, busy} <= run_flags(DONE);
                    buzz_cnt         <= '0;
                    buzzer           <= 1'b1;
`ifdef COOK_CHIME_EN
                    chime_cnt        <= '0;
`endif
                end
            end else if (state == DONE) begin
                if (buzz_cnt == BUZZ_MAX) begin
                    state            <= IDLE;
                    time_q           <= '0;
                    buzzer           <= 1'b0;
                    {power_on, busy} <= run_flags(IDLE);
                end else begin
                    buzz_cnt <= buzz_cnt + BUZZ_W'(1);
`ifdef COOK_CHIME_EN
                    if (chime_cnt == CHIME_MAX) begin
                        chime_cnt <= '0;
                        buzzer    <= ~buzzer;
                    end else begin
                        chime_cnt <= chime_cnt + CHIME_W'(1);
                    end
`endif
                end
            end else if ((state == IDLE) && load) begin
                if (bcd_valid_mmss(load_val)) time_q <= load_val;
                else load_err <= 1'b1;
            end
        end
    end

    assign first_second_out  = time_q.sec_ones;
    assign second_second_out = time_q.sec_tens;
    assign first_minute_out  = time_q.min_ones;
    assign second_minute_out = time_q.min_tens;
    assign state_out         = state;

endmodule

// File: tb/tb_cook_countdown.sv
// Scoreboard bench for cook_countdown: a seconds-based reference model predicts every cycle's outputs.
module tb_cook_countdown;

    localparam int TD  = 4;
    localparam int BC  = 12;
    localparam int ADD = 30;
    localparam int MAX_SECS = 99 * 60 + 59;

    logic       clk = 1'b0;
    logic       reset, load, start, stop, door_open;
    logic [3:0] ld_so, ld_st, ld_mo, ld_mt;
    logic [3:0] so, st, mo, mt;
    logic       power_on, buzzer, busy, load_err;
    logic [1:0] state_out;

    cook_countdown #(.TICK_DIV(TD), .BUZZ_CYCLES(BC), .ADD_SEC(ADD)) dut (
        .clk               (clk),
        .reset             (reset),
        .load              (load),
        .load_sec_ones     (ld_so),
        .load_sec_tens     (ld_st),
        .load_min_ones     (ld_mo),
        .load_min_tens     (ld_mt),
        .start             (start),
        .stop              (stop),
        .door_open         (door_open),
        .first_second_out  (so),
        .second_second_out (st),
        .first_minute_out  (mo),
        .second_minute_out (mt),
        .power_on          (power_on),
        .buzzer            (buzzer),
        .busy              (busy),
        .load_err          (load_err),
        .state_out         (state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] digits;
        logic [5:0]  ctrl;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: time held as total seconds, state as 0..3.
    int m_state, m_secs, m_presc, m_buzz;
    bit m_pend, m_err, sh1, sh2, ph1, ph2;

    task automatic model_step();
        bit   se, pe, dt;
        int   mins;
        obs_t e;
        if (reset) begin
            m_state = 0; m_secs = 0; m_presc = 0; m_buzz = 0;
            m_pend = 0; m_err = 0; sh1 = 0; sh2 = 0; ph1 = 0; ph2 = 0;
        end else begin
            se = sh1 && !sh2;
            pe = ph1 && !ph2;
            sh2 = sh1; sh1 = start;
            ph2 = ph1; ph1 = stop;
            dt = (m_state == 1) && ((m_presc == TD - 1) || m_pend);
            m_err = 0;
            if (m_state == 1) m_presc = (m_presc + 1) % TD;
            if (pe) begin
                m_pend = 0;
                if (m_state == 1) m_state = 2;
                else begin m_state = 0; m_secs = 0; end
            end else if (door_open && m_state == 1) begin
                m_state = 2; m_pend = 0;
            end else if (se && !door_open && m_state != 3) begin
                if (m_state == 0) begin
                    m_presc = 0;
                    if (m_secs == 0) m_secs = ADD;
                    m_state = 1;
                end else if (m_state == 1) begin
                    m_secs = (m_secs + ADD > MAX_SECS) ? MAX_SECS : m_secs + ADD;
                    m_pend = dt;
                end else begin
                    m_state = 1;
                end
            end else if (dt) begin
                m_pend = 0;
                m_secs = m_secs - 1;
                if (m_secs == 0) begin m_state = 3; m_buzz = 0; end
            end else if (m_state == 3) begin
                if (m_buzz == BC - 1) begin m_state = 0; m_secs = 0; end
                else m_buzz++;
            end else if (m_state == 0 && load) begin
                if (ld_mt <= 9 && ld_mo <= 9 && ld_st <= 5 && ld_so <= 9)
                    m_secs = (int'(ld_mt) * 10 + int'(ld_mo)) * 60 + int'(ld_st) * 10 + int'(ld_so);
                else
                    m_err = 1;
            end
        end
        mins = m_secs / 60;
        e.digits = {4'(mins / 10), 4'(mins % 10), 4'((m_secs % 60) / 10), 4'(m_secs % 10)};
        e.ctrl   = {m_state == 1, m_state == 3, (m_state == 1) || (m_state == 2), m_err, 2'(m_state)};
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compare DUT outputs against the queued expectation away from the clock edge.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.digits = {mt, mo, st, so};
                a.ctrl   = {power_on, buzzer, busy, load_err, state_out};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t mmss=%h required=%h pwr/buz/busy/err/st=%b required=%b",
                             $time, a.digits, e.digits, a.ctrl, e.ctrl);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_load(input int a, input int b, input int c, input int d);
        ld_mt = 4'(a); ld_mo = 4'(b); ld_st = 4'(c); ld_so = 4'(d);
        load = 1'b1; cyc(1); load = 1'b0; cyc(1);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(2); start = 1'b0; cyc(1);
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(2); stop = 1'b0; cyc(1);
    endtask

    task automatic wait_presc(input int target, input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_state == 1 && m_presc == target) hit = 1;
            else cyc(1);
        end
        if (!hit) begin
            checks++; failures++;
            $display("FAIL %s timeout waiting for prescaler=%0d (state=%0d)", tag, target, m_state);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; door_open = 1'b0;
        ld_so = '0; ld_st = '0; ld_mo = '0; ld_mt = '0;
        cyc(3);
        reset = 1'b0;
        cyc(2);

        // 01:30 countdown over several ticks, then pause and clear.
        do_load(0, 1, 3, 0); pulse_start(); cyc(22); pulse_stop(); pulse_stop();
        // 00:02 runs out, buzzer window, back to IDLE.
        do_load(0, 0, 0, 2); pulse_start(); cyc(30);
        // +30 with minute carry, then saturation at 99:59.
        do_load(0, 1, 5, 9); pulse_start(); cyc(2); pulse_start(); cyc(3); pulse_stop(); pulse_stop();
        do_load(9, 9, 4, 5); pulse_start(); cyc(2); pulse_start(); cyc(6); pulse_stop(); pulse_stop();
        // Door pause, start ignored while open, resume after close.
        do_load(0, 0, 4, 0); pulse_start(); cyc(3);
        door_open = 1'b1; cyc(3); pulse_start(); cyc(2);
        door_open = 1'b0; cyc(2); pulse_start(); cyc(10); pulse_stop(); pulse_stop();
        // Rejected load leaves time unchanged; stop twice.
        do_load(0, 1, 7, 5); do_load(0, 1, 1, 0); pulse_start(); cyc(3); pulse_stop(); cyc(2); pulse_stop();
        // Quick start from 00:00, start edge coinciding with a tick.
        pulse_start(); cyc(2); wait_presc(2, "add_tick"); pulse_start(); cyc(8);
        // Door opening on a tick cycle discards the tick.
        wait_presc(3, "door_tick"); door_open = 1'b1; cyc(4); door_open = 1'b0; cyc(1);
        pulse_start(); cyc(6); pulse_stop(); pulse_stop();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                load  = 1'b1;
                ld_mt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 11)) : 4'd0;
                ld_mo = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 11)) : 4'd0;
                ld_st = 4'($urandom_range(0, 7));
                ld_so = 4'($urandom_range(0, 11));
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) start = ~start;
            if ($urandom_range(0, 24) == 0) stop = ~stop;
            if ($urandom_range(0, 29) == 0) door_open = ~door_open;
            reset = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; door_open = 1'b0;
        cyc(5);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
